div_seq: RTL and testbench

DIV_SEQ -- requirements
Module: div_seq

---
 rtl/div_pkg.sv | 16 +
 rtl/div_sign_fix.sv | 54 +++++
 rtl/div_seq.sv | 152 +++++++++++++++
 tb/tb_div_seq.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding and
// the sizing rule for the iteration counter.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must hold the value WIDTH itself, hence WIDTH+1 codes.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Sign handling around the unsigned restoring core: converts operands to
// magnitudes before the divide and restores result signs afterwards.
// With SIGNED = 0 every path is a straight pass-through.
module div_sign_fix
    import div_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter bit SIGNED = 1'b0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] a_mag,
    output logic [WIDTH-1:0] b_mag,
    output logic             sgn_q,
    output logic             sgn_r,
    input  logic [WIDTH-1:0] q_mag,
    input  logic [WIDTH-1:0] r_mag,
    input  logic             neg_q,
    input  logic             neg_r,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] r
);

    // Two's-complement negate when requested. The most negative value maps
    // onto itself, which read as unsigned is exactly its magnitude.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                  input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    logic neg_a;
    logic neg_b;

    // Operand magnitudes and the result signs they imply.
    always_comb begin
        neg_a = 1'b0;
        neg_b = 1'b0;
        if (SIGNED) begin
            neg_a = a[WIDTH-1];
            neg_b = b[WIDTH-1];
        end
        a_mag = cond_neg(a, neg_a);
        b_mag = cond_neg(b, neg_b);
        sgn_q = neg_a ^ neg_b;
        sgn_r = neg_a;
    end

    // Re-apply the signs captured at acceptance to the unsigned results.
    always_comb begin
        y = cond_neg(q_mag, neg_q);
        r = cond_neg(r_mag, neg_r);
    end

endmodule

// File: rtl/div_seq.sv
// Sequential restoring divider: one shift-subtract iteration per clock,
// WIDTH iterations per result, optional two's-complement operation.
// Divide-by-zero bypasses the iterations and reports through dz.
module div_seq
    import div_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic             dz
);

    localparam int              CNT_W    = cnt_width(WIDTH);
    localparam int              RW       = WIDTH + 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Iteration datapath: rem is the partial remainder, quo shifts the
    // dividend out at the top while quotient bits enter at the bottom.
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvsr;
    logic             neg_q;
    logic             neg_r;

    logic [WIDTH+1:0] part;
    logic [WIDTH:0]   rem_nxt;
    logic [WIDTH-1:0] quo_nxt;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             sgn_q;
    logic             sgn_r;
    logic [WIDTH-1:0] y_fix;
    logic [WIDTH-1:0] r_fix;

    logic             accept;

    assign accept = ld && ((state == IDLE) || (state == DONE));

    div_sign_fix #(
        .WIDTH  (WIDTH),
        .SIGNED (SIGNED)
    ) u_sign_fix (
        .a     (a),
        .b     (b),
        .a_mag (a_mag),
        .b_mag (b_mag),
        .sgn_q (sgn_q),
        .sgn_r (sgn_r),
        .q_mag (quo_nxt),
        .r_mag (rem_nxt[WIDTH-1:0]),
        .neg_q (neg_q),
        .neg_r (neg_r),
        .y     (y_fix),
        .r     (r_fix)
    );

    // One restoring step: shift in the next dividend bit, subtract the
    // divisor if it fits, and record the outcome as the next quotient bit.
    always_comb begin
        part = {rem, quo[WIDTH-1]};
        if (part >= {2'b00, dvsr}) begin
            rem_nxt = RW'(part - {2'b00, dvsr});
            quo_nxt = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_nxt = RW'(part);
            quo_nxt = {quo[WIDTH-2:0], 1'b0};
        end
    end

    // Datapath registers: loaded on acceptance, stepped while running.
    always_ff @(posedge clk) begin
        if (accept) begin
            rem   <= '0;
            quo   <= a_mag;
            dvsr  <= b_mag;
            neg_q <= sgn_q;
            neg_r <= sgn_r;
        end else if (state == RUN) begin
            rem   <= rem_nxt;
            quo   <= quo_nxt;
        end
    end

    // Sequencer with registered status and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            y     <= '0;
            r     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            dz    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (ld) begin
                        if (b == '0) begin
                            state <= DONE;
                            cnt   <= '0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            y     <= '1;
                            r     <= a;
                            dz    <= 1'b1;
                        end else begin
                            state <= RUN;
                            cnt   <= CNT_INIT;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                end
                RUN: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        y     <= y_fix;
                        r     <= r_fix;
                        dz    <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: one unsigned and one signed 4-bit
// instance, directed scenarios followed by randomized operations checked
// against an integer-arithmetic reference model.
module tb_div_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ld_u, ld_s;
    logic [3:0] a_u, b_u, a_s, b_s;
    logic [3:0] y_u, r_u, y_s, r_s;
    logic       busy_u, done_u, dz_u;
    logic       busy_s, done_s, dz_s;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    div_seq #(.WIDTH(4), .SIGNED(1'b0)) u_dut_u (
        .clk(clk), .rst_n(rst_n), .ld(ld_u), .a(a_u), .b(b_u),
        .y(y_u), .r(r_u), .busy(busy_u), .done(done_u), .dz(dz_u)
    );

    div_seq #(.WIDTH(4), .SIGNED(1'b1)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .ld(ld_s), .a(a_s), .b(b_s),
        .y(y_s), .r(r_s), .busy(busy_s), .done(done_s), .dz(dz_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic       get_done(input bit s); return s ? done_s : done_u; endfunction
    function automatic logic       get_busy(input bit s); return s ? busy_s : busy_u; endfunction
    function automatic logic       get_dz  (input bit s); return s ? dz_s   : dz_u;   endfunction
    function automatic logic [3:0] get_y   (input bit s); return s ? y_s    : y_u;    endfunction
    function automatic logic [3:0] get_r   (input bit s); return s ? r_s    : r_u;    endfunction

    // Reference: plain integer division (truncating toward zero in SV).
    task automatic model(input bit s, input logic [3:0] av, input logic [3:0] bv,
                         output logic [3:0] ey, output logic [3:0] er, output logic edz);
        int ia, ib, q, rm;
        if (bv == 4'd0) begin
            ey = 4'hF; er = av; edz = 1'b1;
        end else begin
            if (s) begin
                ia = int'($signed(av));
                ib = int'($signed(bv));
            end else begin
                ia = int'(av);
                ib = int'(bv);
            end
            q  = ia / ib;
            rm = ia % ib;
            ey = q[3:0];
            er = rm[3:0];
            edz = 1'b0;
        end
    endtask

    task automatic drive(input bit s, input logic l, input logic [3:0] av, input logic [3:0] bv);
        if (s) begin ld_s = l; a_s = av; b_s = bv; end
        else   begin ld_u = l; a_u = av; b_u = bv; end
    endtask

    // Called at a negedge; holds ld across exactly one rising edge.
    task automatic start(input bit s, input logic [3:0] av, input logic [3:0] bv);
        drive(s, 1'b1, av, bv);
        @(negedge clk);
        drive(s, 1'b0, 4'($urandom), 4'($urandom));
    endtask

    // Called at the negedge after acceptance; returns at the done sample.
    task automatic finish(input bit s, input logic [3:0] av, input logic [3:0] bv,
                          input bit inject, input string tag);
        logic [3:0] ey, er;
        logic       edz;
        int         k, nb, lat;
        bit         got;
        model(s, av, bv, ey, er, edz);
        lat = (bv == 4'd0) ? 0 : 4;
        k = 0; nb = 0; got = 1'b0;
        while (!got && k < 20) begin
            if (get_done(s)) begin
                got = 1'b1;
            end else begin
                if (get_busy(s)) nb++;
                if (inject && k == 1) drive(s, 1'b1, 4'hF, 4'h1);
                @(negedge clk);
                if (inject && k == 1) drive(s, 1'b0, 4'($urandom), 4'($urandom));
                k++;
            end
        end
        check({tag, " done_seen"}, 32'(got), 32'd1);
        check({tag, " latency"},   32'(k),   32'(lat));
        check({tag, " busy_cyc"},  32'(nb),  32'(lat));
        check({tag, " y"},         32'(get_y(s)),  32'(ey));
        check({tag, " r"},         32'(get_r(s)),  32'(er));
        check({tag, " dz"},        32'(get_dz(s)), 32'(edz));
    endtask

    task automatic do_op(input bit s, input logic [3:0] av, input logic [3:0] bv, input string tag);
        start(s, av, bv);
        finish(s, av, bv, 1'b0, tag);
        @(negedge clk);
        check({tag, " done_pulse"}, 32'(get_done(s)), 32'd0);
        check({tag, " idle_busy"},  32'(get_busy(s)), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int extra;
        bit s;
        logic [3:0] av, bv, av2, bv2;

        rst_n = 1'b0;
        ld_u = 1'b0; a_u = '0; b_u = '0;
        ld_s = 1'b0; a_s = '0; b_s = '0;
        #1;
        check("reset y",    32'(y_u),    32'd0);
        check("reset r",    32'(r_u),    32'd0);
        check("reset busy", 32'(busy_u), 32'd0);
        check("reset done", 32'(done_u), 32'd0);
        check("reset dz",   32'(dz_u),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic unsigned divide: 11 / 2
        do_op(1'b0, 4'b1011, 4'b0010, "u11div2");

        // Back-to-back: second ld issued in the DONE cycle
        start(1'b0, 4'b1001, 4'b1000);
        finish(1'b0, 4'b1001, 4'b1000, 1'b0, "b2b_first");
        start(1'b0, 4'b1111, 4'b0011);
        finish(1'b0, 4'b1111, 4'b0011, 1'b0, "b2b_second");
        @(negedge clk);
        check("b2b done_pulse", 32'(done_u), 32'd0);

        // Divide by zero
        do_op(1'b0, 4'b0110, 4'b0000, "divzero");

        // ld during RUN must be ignored
        start(1'b0, 4'b1011, 4'b0010);
        finish(1'b0, 4'b1011, 4'b0010, 1'b1, "ld_in_run");
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done_u) extra++;
        end
        check("ld_in_run extra_done", 32'(extra), 32'd0);

        // Signed divides, including the overflow case
        do_op(1'b1, 4'b1001, 4'b0010, "s_m7div2");
        do_op(1'b1, 4'b1000, 4'b1111, "s_ovf");

        // Asynchronous reset mid-RUN
        start(1'b0, 4'b1011, 4'b0010);
        @(negedge clk);
        check("rst_mid busy_before", 32'(busy_u), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid y",    32'(y_u),    32'd0);
        check("rst_mid r",    32'(r_u),    32'd0);
        check("rst_mid busy", 32'(busy_u), 32'd0);
        check("rst_mid done", 32'(done_u), 32'd0);
        check("rst_mid dz",   32'(dz_u),   32'd0);
        rst_n = 1'b1;
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done_u) extra++;
        end
        check("rst_mid no_done", 32'(extra), 32'd0);
        do_op(1'b0, 4'b1011, 4'b0010, "after_rst");

        // Randomized single operations on both flavours
        for (int i = 0; i < 30; i++) begin
            s  = 1'($urandom_range(0, 1));
            av = 4'($urandom);
            bv = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
            do_op(s, av, bv, s ? "rand_s" : "rand_u");
        end

        // Randomized back-to-back pairs
        for (int i = 0; i < 10; i++) begin
            s   = 1'($urandom_range(0, 1));
            av  = 4'($urandom);
            bv  = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom);
            av2 = 4'($urandom);
            bv2 = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom);
            start(s, av, bv);
            finish(s, av, bv, 1'b0, "rand_b2b_a");
            start(s, av2, bv2);
            finish(s, av2, bv2, 1'b0, "rand_b2b_b");
            @(negedge clk);
            check("rand_b2b done_pulse", 32'(get_done(s)), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
